// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the iterative divider.
//   DIV_W      operand width
//   DIV_STEPS  number of radix-2 steps per division
//   CNT_W      width of the step counter
//   div_state_e  FSM state encoding used by div_iter
//   cond_neg   two's-complement negate when the flag is set
package div_pkg;

    localparam int unsigned DIV_W     = 32;
    localparam int unsigned DIV_STEPS = 32;
    localparam int unsigned CNT_W     = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v,
                                                  input logic             neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring radix-2 division step.
// The {rem, quo} pair is shifted left by one bit; the divisor is subtracted
// from the shifted remainder when it fits, and the quotient LSB records
// whether it did.
//   rem_i  partial remainder before the step
//   quo_i  dividend bits still to be consumed / quotient bits produced so far
//   dvs_i  divisor magnitude
//   rem_o  partial remainder after the step
//   quo_o  shifted quotient with the new bit in the LSB
module div_step
    import div_pkg::*;
(
    input  logic [DIV_W-1:0] rem_i,
    input  logic [DIV_W-1:0] quo_i,
    input  logic [DIV_W-1:0] dvs_i,
    output logic [DIV_W-1:0] rem_o,
    output logic [DIV_W-1:0] quo_o
);

    logic [DIV_W:0] partial;
    logic           fits;

    assign partial = {rem_i, quo_i[DIV_W-1]};
    assign fits    = (partial >= {1'b0, dvs_i});

    // When the subtraction succeeds the difference is always below the
    // divisor, so the top bit dropped by the cast is zero.
    assign rem_o = fits ? DIV_W'(partial - {1'b0, dvs_i}) : partial[DIV_W-1:0];
    assign quo_o = {quo_i[DIV_W-2:0], fits};

endmodule

// File: rtl/div_iter.sv
// div_iter -- 32-bit iterative signed/unsigned divider, one bit per cycle.
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   scr0       dividend, sampled on accept
//   scr1       divisor, sampled on accept
//   divop      1 = signed, 0 = unsigned, sampled on accept
//   div_valid  request valid
//   div_ready  request accepted when div_valid && div_ready
//   cancel     flush: returns to IDLE from any state, beats accept/handshake
//   res_valid  div_res is valid
//   res_ready  consumer takes result when res_valid && res_ready
//   div_res    {remainder, quotient}
// Optional feature: DIV_ZERO_FAST_EN -- a zero divisor skips the iteration
// and returns {scr0, all-ones} on the cycle after accept.
//
// state | meaning
// IDLE  | waiting for a request, div_ready high
// CALC  | 32 restoring steps on the latched magnitudes
// DONE  | sign-corrected result held until consumed
module div_iter
    import div_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_W-1:0]     scr0,
    input  logic [DIV_W-1:0]     scr1,
    input  logic                 divop,
    input  logic                 div_valid,
    output logic                 div_ready,
    input  logic                 cancel,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [2*DIV_W-1:0]   div_res
);

    div_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIV_W-1:0]   rem_q, rem_d;
    logic [DIV_W-1:0]   quo_q, quo_d;
    logic [DIV_W-1:0]   dvs_q, dvs_d;
    logic               qneg_q, qneg_d;
    logic               rneg_q, rneg_d;
    logic [2*DIV_W-1:0] res_q, res_d;

    logic [DIV_W-1:0]   step_rem, step_quo;
    logic               sgn_a, sgn_b;
    logic               accept;

    assign div_ready = (state_q == IDLE);
    assign res_valid = (state_q == DONE);
    assign div_res   = res_q;

    assign accept = div_valid && div_ready;
    assign sgn_a  = divop & scr0[DIV_W-1];
    assign sgn_b  = divop & scr1[DIV_W-1];

    div_step u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        res_d   = res_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    // Iterate on magnitudes; signs are reapplied at the end.
                    rem_d  = '0;
                    quo_d  = cond_neg(scr0, sgn_a);
                    dvs_d  = cond_neg(scr1, sgn_b);
                    qneg_d = sgn_a ^ sgn_b;
                    rneg_d = sgn_a;
                    cnt_d  = '0;
`ifdef DIV_ZERO_FAST_EN
                    if (scr1 == '0) begin
                        state_d = DONE;
                        res_d   = {scr0, {DIV_W{1'b1}}};
                    end else begin
                        state_d = CALC;
                    end
`else
                    state_d = CALC;
`endif
                end
            end
            CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    // Sign correction folded into the last step's register
                    // write so the result appears without an extra cycle.
                    state_d = DONE;
                    cnt_d   = '0;
                    res_d   = {cond_neg(step_rem, rneg_q), cond_neg(step_quo, qneg_q)};
                end
            end
            DONE: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (cancel) begin
            state_d = IDLE;
            cnt_d   = '0;
            res_d   = res_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            res_q   <= res_d;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter -- self-checking bench for div_iter.
// Builds with or without DIV_ZERO_FAST_EN; expected values follow the macro.
module tb_div_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] scr0, scr1;
    logic        divop, div_valid, div_ready, cancel;
    logic        res_valid, res_ready;
    logic [63:0] div_res;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_iter dut (
        .clk       (clk),
        .rst       (rst),
        .scr0      (scr0),
        .scr1      (scr1),
        .divop     (divop),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .cancel    (cancel),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .div_res   (div_res)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        logic [63:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on magnitudes, then signs reapplied.
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic op);
        logic neg_a, neg_b;
        longint unsigned ma, mb, qm, rm;
        logic [31:0] q, r;
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
`endif
        neg_a = op & a[31];
        neg_b = op & b[31];
        ma = neg_a ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        mb = neg_b ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
        if (mb == 0) begin
            qm = 64'hFFFF_FFFF;
            rm = ma;
        end else begin
            qm = ma / mb;
            rm = ma % mb;
        end
        q = (neg_a ^ neg_b) ? (32'h0 - qm[31:0]) : qm[31:0];
        r = neg_a ? (32'h0 - rm[31:0]) : rm[31:0];
        return {r, q};
    endfunction

    function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
        if (b == 32'h0) return 1;
`endif
        return 33;
    endfunction

    // Called just after a falling edge. Accepts one request, waits for the
    // result (bounded), optionally stalls the consumer for 'hold' cycles and
    // optionally keeps div_valid high with garbage operands while busy.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic op,
                          input int hold, input bit junk,
                          output logic [63:0] res, output int lat);
        div_valid = 1'b1;
        scr0 = a;
        scr1 = b;
        divop = op;
        check("ready_before_accept", div_ready, 1);
        @(posedge clk);
        #1;
        if (junk) begin
            scr0 = $urandom;
            scr1 = $urandom;
            divop = ~op;
        end else begin
            div_valid = 1'b0;
        end
        lat = 0;
        res = '0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (res_valid) begin
                lat = n;
                break;
            end
            @(posedge clk);
        end
        div_valid = 1'b0;
        if (lat == 0) begin
            checks++;
            errors++;
            $display("FAIL res_valid_timeout actual=never required=within 100 cycles");
        end else begin
            res = div_res;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                check("hold_res_stable", div_res, res);
                check("hold_res_valid", res_valid, 1);
                check("hold_ready_low", div_ready, 0);
            end
            res_ready = 1'b1;
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            @(negedge clk);
            check("ready_after_take", div_ready, 1);
            check("valid_after_take", res_valid, 0);
        end
    endtask

    task automatic count_valid(input int cycles, output int seen);
        seen = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
    endtask

    vec_t        vecs[$];
    logic [63:0] res;
    int          lat;
    int          seen;
    logic [31:0] ra, rb;
    logic        rop;

    initial begin
        vecs.push_back('{32'd100,        32'd7,          1'b0, {32'd2,          32'd14}});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b1, {32'hFFFF_FFFF,  32'hFFFF_FFFD}});
        vecs.push_back('{32'h8000_0000,  32'hFFFF_FFFF,  1'b1, {32'h0,          32'h8000_0000}});
        vecs.push_back('{32'h1234_5678,  32'h0,          1'b0, {32'h1234_5678,  32'hFFFF_FFFF}});
        vecs.push_back('{32'hFFFF_FFFF,  32'd1,          1'b0, {32'h0,          32'hFFFF_FFFF}});
        vecs.push_back('{32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, {32'h0,          32'h1}});
        vecs.push_back('{32'd7,          32'hFFFF_FFF9,  1'b1, {32'h0,          32'hFFFF_FFFF}});
        vecs.push_back('{32'd5,          32'd10,         1'b0, {32'd5,          32'd0}});
        vecs.push_back('{32'hFFFF_FF9C,  32'd7,          1'b1, {32'hFFFF_FFFE,  32'hFFFF_FFF2}});
        vecs.push_back('{32'hFFFF_FFF9,  32'd2,          1'b0, {32'd1,          32'h7FFF_FFFC}});

        rst = 1'b1;
        scr0 = '0;
        scr1 = '0;
        divop = 1'b0;
        div_valid = 1'b0;
        cancel = 1'b0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_res_valid", res_valid, 0);
        check("reset_div_res", div_res, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", div_ready, 1);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].op, 0, 1'b0, res, lat);
            check("vec_res", res, vecs[i].exp);
            check("vec_latency", lat, exp_lat(vecs[i].b));
        end

        // Busy operation ignores div_valid; consumer stalls 5 cycles.
        run_op(32'd1000, 32'd3, 1'b0, 5, 1'b1, res, lat);
        check("busy_ignore_res", res, {32'd1, 32'd333});

        // Signed divide by zero.
        run_op(32'hFFFF_FFEC, 32'h0, 1'b1, 0, 1'b0, res, lat);
        check("sdiv0_res", res, model(32'hFFFF_FFEC, 32'h0, 1'b1));
        check("sdiv0_latency", lat, exp_lat(32'h0));

        // Cancel mid-CALC, then a fresh request right away.
        div_valid = 1'b1;
        scr0 = 32'd100;
        scr1 = 32'd7;
        divop = 1'b0;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        seen = 0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_ready", div_ready, 1);
        check("cancel_no_valid", seen + int'(res_valid), 0);
        run_op(32'd50, 32'd5, 1'b0, 0, 1'b0, res, lat);
        check("after_cancel_res", res, {32'd0, 32'd10});
        check("after_cancel_latency", lat, 33);

        // Cancel beats accept in the same cycle (zero divisor also covers the fast path).
        div_valid = 1'b1;
        cancel = 1'b1;
        scr0 = 32'd9;
        scr1 = 32'd0;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        cancel = 1'b0;
        count_valid(40, seen);
        check("cancel_over_accept_valid", seen, 0);
        check("cancel_over_accept_ready", div_ready, 1);

        // Random operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            case ($urandom_range(0, 7))
                0: rb = 32'h0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 255);
                default: rb = $urandom;
            endcase
            rop = 1'($urandom_range(0, 1));
            run_op(ra, rb, rop, 0, 1'b0, res, lat);
            check("rand_res", res, model(ra, rb, rop));
            check("rand_latency", lat, exp_lat(rb));
        end

        // Leave a non-zero result in the output register before the reset tests.
        run_op(32'd77, 32'd5, 1'b0, 0, 1'b0, res, lat);
        check("pre_reset_res", res, {32'd2, 32'd15});

        // Asynchronous reset mid-CALC.
        div_valid = 1'b1;
        scr0 = 32'd77;
        scr1 = 32'd5;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_res", div_res, 0);
        check("async_rst_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        count_valid(40, seen);
        check("rst_calc_no_valid", seen, 0);
        check("rst_calc_ready", div_ready, 1);

        // Asynchronous reset while a result waits in DONE.
        div_valid = 1'b1;
        scr0 = 32'd91;
        scr1 = 32'd4;
        @(posedge clk);
        #1;
        div_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (res_valid) begin
                seen = 1;
                break;
            end
        end
        check("done_reached", seen, 1);
        check("done_res", div_res, {32'd3, 32'd22});
        #2;
        rst = 1'b1;
        #1;
        check("rst_done_res", div_res, 0);
        check("rst_done_valid", res_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        count_valid(40, seen);
        check("rst_done_no_valid", seen, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
